mem_sram_ctrl: RTL and testbench
================================

# mem_sram_ctrl

MEM-stage controller between the pipeline's load/store signals and an external 16-bit asynchronous SRAM. It splits each 32-bit word access into two 16-bit SRAM cycles and stalls the pipeline via `ready` until the access completes. Its `read_data` is the load result that the MEM/WB register carries to the register-file write port `Write_Val`.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `WAIT_CYCLES`, default 3: idle settle cycles after the two half-word cycles; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_r_en`  in  1  load request; held stable by the pipeline while `ready`=0.
- `mem_w_en`  in  1  store request; same hold rule.
- `address`  in  32  byte address, word aligned; bits [1:0] are ignored.
- `write_data`  in  32  store data.
- `read_data`  out  32  load result; registered.
- `ready`  out  1  0 stalls the pipeline (freeze = ~ready).
- `sram_addr`  out  18  SRAM half-word address.
- `sram_dq_out`  out  16  data driven to SRAM.
- `sram_dq_oe`  out  1  1 means the pad drives `sram_dq_out`.
- `sram_dq_in`  in  16  data sampled from SRAM.
- `sram_we_n`  out  1  SRAM write strobe, active-low.

## Operation
- Word index: `w = (address - BASE_ADDR) >> 2`, truncated to 17 bits, so it wraps modulo 2^17. Addresses below `BASE_ADDR` wrap the same way; there is no error output.
- Half-word addresses: low half = `{w[16:0],1'b0}`, holds data[15:0]. High half = `{w[16:0],1'b1}`, holds data[31:16].
- FSM states: IDLE, LO, HI, WAIT, DONE.
- IDLE:
  - `ready = ~(mem_r_en | mem_w_en)`.
  - On a request: latch `w`, `write_data` and the operation, then go to LO.
  - If both enables are set, the access is a write.
- LO, one cycle:
  - `sram_addr` = low-half address.
  - Write: `sram_dq_oe`=1, `sram_dq_out`=data[15:0], `sram_we_n`=0.
  - Read: `sram_dq_oe`=0; `sram_dq_in` is captured into the low staging register at the cycle-ending edge.
  - Next state: HI.
- HI, one cycle: same as LO for the high half. On a read, `read_data <= {sram_dq_in, lo_stage}` at the cycle-ending edge. Next state: WAIT.
- WAIT:
  - Held for `WAIT_CYCLES` cycles by a 4-bit counter that clears on WAIT entry.
  - `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr` holds the high-half address.
  - Next state: DONE.
- DONE, one cycle: `ready`=1, `read_data` is valid. Next state: IDLE unconditionally.
- A request still asserted in the DONE cycle is the completed one and is not re-issued. A request seen in the following IDLE cycle starts a new access.
- `read_data` changes only at the end of a read's HI cycle. It holds its value across writes and idle periods.
- `ready`=0 in LO, HI and WAIT.

## Timing
- Reset values (all outputs; asynchronous assertion, synchronous release):
  - FSM = IDLE, WAIT counter = 0.
  - `read_data`=0, `lo_stage`=0.
  - `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0.
  - `ready` follows the IDLE rule.
- Reset mid-access aborts immediately with no further SRAM strobes. The partial write is not repeated.
- Access latency, with the request first seen in cycle 0 (IDLE):
  - LO in cycle 1, HI in cycle 2.
  - WAIT in cycles 3 .. 2+`WAIT_CYCLES`.
  - DONE in cycle 3+`WAIT_CYCLES`.
- Stall length is 3+`WAIT_CYCLES` cycles; the default is 6 cycles, with `ready` high in cycle 6.
- Outputs are combinational from the FSM state and registers. There is no combinational path from `sram_dq_in` to any output.

## Configuration
- Macro `SRAM_FAST_WRITE_EN`.
- Defined: write accesses go HI -> DONE and skip WAIT, so a write completes in cycle 3. Reads are unchanged.
- Undefined: reads and writes both pass through WAIT.

## Test plan
- Read, default parameters. `address`=1024, SRAM half 0 = 16'h5678, half 1 = 16'h1234. Required: `ready`=0 for cycles 0–5 and 1 in cycle 6; `read_data`=32'h12345678 in cycle 6.
- Write at `address`=1032, data 32'hDEADBEEF. Required:
  - Cycle 1: `sram_we_n`=0, `sram_addr`=4, `sram_dq_out`=16'hBEEF.
  - Cycle 2: `sram_addr`=5, `sram_dq_out`=16'hDEAD.
  - Cycle 6: `ready`=1.
  - With `SRAM_FAST_WRITE_EN`: `ready`=1 in cycle 3.
- Back-to-back: a load, then a store presented in the cycle after DONE. Required: exactly two accesses, no re-issue of the load; `read_data` keeps the load value after the store completes.
- Both enables at `address`=1024, data 32'hA5A5A5A5. Required: a write occurs (`sram_we_n`=0 in cycles 1–2); `read_data` is unchanged.
- `rst` low during HI of a write. Required: immediately `sram_we_n`=1, `sram_dq_oe`=0, `read_data`=0. After release, with the request still asserted, a fresh access starts and completes.
- Wrap: `address`=1024 + 4*2^17. Required: `sram_addr`=0 and then 1.

Source files
------------

// File: rtl/mem_sram_ctrl_if.sv
// Pipeline-side load/store bus of the MEM-stage SRAM controller.
// The pipeline is the master; mem_sram_ctrl is the slave.
interface mem_sram_ctrl_if;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;

   modport master (
      output mem_r_en,
      output mem_w_en,
      output address,
      output write_data,
      input  read_data,
      input  ready
   );

   modport slave (
      input  mem_r_en,
      input  mem_w_en,
      input  address,
      input  write_data,
      output read_data,
      output ready
   );
endinterface

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller: splits 32-bit loads/stores into two 16-bit async SRAM cycles.
// Optional macro SRAM_FAST_WRITE_EN lets writes skip the WAIT settle phase.
module mem_sram_ctrl #(
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int unsigned WAIT_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_sram_ctrl_if.slave        bus,
   output logic [17:0]           sram_addr,
   output logic [15:0]           sram_dq_out,
   output logic                  sram_dq_oe,
   input  logic [15:0]           sram_dq_in,
   output logic                  sram_we_n
);

   typedef enum logic [2:0] {
      IDLE,
      LO,
      HI,
      WAIT,
      DONE
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

   state_t      state;
   logic [3:0]  wait_cnt;
   logic        is_write;
   logic [16:0] word_idx;
   logic [15:0] wdata_hi;
   logic [15:0] lo_stage;
   logic [31:0] read_data_q;

   logic [31:0] aligned_addr;
   logic [31:0] offset;
   logic [16:0] word_next;
   logic        request;
   logic        unused_bits;

   // Word index wraps modulo 2^17; the discarded offset bits are deliberately unused.
   assign aligned_addr = {bus.address[31:2], 2'b00};
   assign offset       = aligned_addr - BASE_ADDR;
   assign word_next    = offset[18:2];
   assign unused_bits  = ^{offset[31:19], offset[1:0], bus.address[1:0]};
   assign request      = bus.mem_r_en | bus.mem_w_en;

   assign bus.ready     = (state == DONE) || ((state == IDLE) && !request);
   assign bus.read_data = read_data_q;

   // Single FSM; every SRAM pin is registered and set up on the edge entering its phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         wait_cnt    <= 4'd0;
         is_write    <= 1'b0;
         word_idx    <= 17'd0;
         wdata_hi    <= 16'd0;
         lo_stage    <= 16'd0;
         read_data_q <= 32'd0;
         sram_addr   <= 18'd0;
         sram_dq_out <= 16'd0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (request) begin
                  is_write  <= bus.mem_w_en;
                  word_idx  <= word_next;
                  wdata_hi  <= bus.write_data[31:16];
                  sram_addr <= {word_next, 1'b0};
                  if (bus.mem_w_en) begin
                     sram_dq_out <= bus.write_data[15:0];
                     sram_dq_oe  <= 1'b1;
                     sram_we_n   <= 1'b0;
                  end else begin
                     sram_dq_oe  <= 1'b0;
                     sram_we_n   <= 1'b1;
                  end
                  state <= LO;
               end
            end
            LO: begin
               if (!is_write) begin
                  lo_stage <= sram_dq_in;
               end else begin
                  sram_dq_out <= wdata_hi;
               end
               sram_addr <= {word_idx, 1'b1};
               state     <= HI;
            end
            HI: begin
               if (!is_write) begin
                  read_data_q <= {sram_dq_in, lo_stage};
               end
               sram_we_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
               wait_cnt   <= 4'd0;
`ifdef SRAM_FAST_WRITE_EN
               state <= is_write ? DONE : WAIT;
`else
               state <= WAIT;
`endif
            end
            WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  state <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed self-checking bench for mem_sram_ctrl with a behavioural 16-bit SRAM model.
// Expected write completion cycle follows SRAM_FAST_WRITE_EN.
module tb_mem_sram_ctrl;

   localparam int RD_DONE = 6;
`ifdef SRAM_FAST_WRITE_EN
   localparam int WR_DONE = 3;
`else
   localparam int WR_DONE = 6;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;

   int checks = 0;
   int errors = 0;

   logic [15:0] sram_mem [0:262143];
   bit          init_done;
   int          strobe_count = 0;
   int          strobes_before;

   logic [17:0] addr_c1, addr_c2;
   logic        we_c1, we_c2, oe_c1;
   logic [15:0] dq_c1, dq_c2;

   mem_sram_ctrl_if bus ();

   mem_sram_ctrl #(
      .BASE_ADDR   (32'd1024),
      .WAIT_CYCLES (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_oe  (sram_dq_oe),
      .sram_dq_in  (sram_dq_in),
      .sram_we_n   (sram_we_n)
   );

   always #5 clk = ~clk;

   // SRAM model: preloads on the first edge, then stores every strobed half-word.
   assign sram_dq_in = sram_mem[sram_addr];
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 8; i++) sram_mem[i] <= 16'h0000;
         sram_mem[0]      <= 16'h5678;
         sram_mem[1]      <= 16'h1234;
         sram_mem[2]      <= 16'hCAFE;
         sram_mem[3]      <= 16'hBABE;
         sram_mem[262142] <= 16'h0000;
         sram_mem[262143] <= 16'h0000;
         init_done        <= 1'b1;
      end else if (!sram_we_n && sram_dq_oe) begin
         sram_mem[sram_addr] <= sram_dq_out;
         strobe_count        <= strobe_count + 1;
      end
   end

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      next_cycle();
      bus.mem_r_en = 1'b0;
      bus.mem_w_en = 1'b0;
      @(negedge clk);
   endtask

   // Presents a request in cycle 0 and checks ready every cycle up to the DONE cycle.
   task automatic apply_stimulus(input string name, input logic r, input logic w,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input int done_cycle);
      next_cycle();
      bus.mem_r_en   = r;
      bus.mem_w_en   = w;
      bus.address    = addr;
      bus.write_data = data;
      strobes_before = strobe_count;
      for (int c = 0; c <= done_cycle; c++) begin
         if (c != 0) next_cycle();
         @(negedge clk);
         check_output($sformatf("%s_ready_c%0d", name, c), {31'b0, bus.ready},
                      {31'b0, (c == done_cycle)});
         if (c == 1) begin
            addr_c1 = sram_addr;
            we_c1   = sram_we_n;
            oe_c1   = sram_dq_oe;
            dq_c1   = sram_dq_out;
         end
         if (c == 2) begin
            addr_c2 = sram_addr;
            we_c2   = sram_we_n;
            dq_c2   = sram_dq_out;
         end
      end
   endtask

   initial begin
      bus.mem_r_en   = 1'b0;
      bus.mem_w_en   = 1'b0;
      bus.address    = 32'd0;
      bus.write_data = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("rst_read_data", bus.read_data, 32'd0);
      check_output("rst_we_n", {31'b0, sram_we_n}, 32'd1);
      check_output("rst_oe", {31'b0, sram_dq_oe}, 32'd0);
      check_output("rst_addr", {14'b0, sram_addr}, 32'd0);
      check_output("rst_dq_out", {16'b0, sram_dq_out}, 32'd0);
      check_output("rst_ready", {31'b0, bus.ready}, 32'd1);
      rst = 1'b1;

      $display("[TB] read at 1024");
      apply_stimulus("rd", 1'b1, 1'b0, 32'd1024, 32'd0, RD_DONE);
      check_output("rd_addr_c1", {14'b0, addr_c1}, 32'd0);
      check_output("rd_oe_c1", {31'b0, oe_c1}, 32'd0);
      check_output("rd_we_c1", {31'b0, we_c1}, 32'd1);
      check_output("rd_addr_c2", {14'b0, addr_c2}, 32'd1);
      check_output("rd_data", bus.read_data, 32'h12345678);
      go_idle();

      $display("[TB] write at 1032");
      apply_stimulus("wr", 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, WR_DONE);
      check_output("wr_we_c1", {31'b0, we_c1}, 32'd0);
      check_output("wr_addr_c1", {14'b0, addr_c1}, 32'd4);
      check_output("wr_dq_c1", {16'b0, dq_c1}, 32'h0000BEEF);
      check_output("wr_we_c2", {31'b0, we_c2}, 32'd0);
      check_output("wr_addr_c2", {14'b0, addr_c2}, 32'd5);
      check_output("wr_dq_c2", {16'b0, dq_c2}, 32'h0000DEAD);
      check_output("wr_strobes", strobe_count - strobes_before, 32'd2);
      check_output("wr_mem_lo", {16'b0, sram_mem[4]}, 32'h0000BEEF);
      check_output("wr_mem_hi", {16'b0, sram_mem[5]}, 32'h0000DEAD);
      check_output("wr_keeps_rd", bus.read_data, 32'h12345678);
      go_idle();

      $display("[TB] back-to-back load then store");
      apply_stimulus("b2b_rd", 1'b1, 1'b0, 32'd1028, 32'd0, RD_DONE);
      check_output("b2b_rd_data", bus.read_data, 32'hBABECAFE);
      apply_stimulus("b2b_wr", 1'b0, 1'b1, 32'd1036, 32'h01020304, WR_DONE);
      check_output("b2b_wr_we_c1", {31'b0, we_c1}, 32'd0);
      check_output("b2b_wr_addr_c1", {14'b0, addr_c1}, 32'd6);
      check_output("b2b_strobes", strobe_count - strobes_before, 32'd2);
      check_output("b2b_mem_hi", {16'b0, sram_mem[7]}, 32'h00000102);
      check_output("b2b_keeps_rd", bus.read_data, 32'hBABECAFE);
      go_idle();

      $display("[TB] both enables");
      apply_stimulus("both", 1'b1, 1'b1, 32'd1024, 32'hA5A5A5A5, WR_DONE);
      check_output("both_we_c1", {31'b0, we_c1}, 32'd0);
      check_output("both_we_c2", {31'b0, we_c2}, 32'd0);
      check_output("both_mem_lo", {16'b0, sram_mem[0]}, 32'h0000A5A5);
      check_output("both_read_data", bus.read_data, 32'hBABECAFE);
      go_idle();

      $display("[TB] reset during HI of a write");
      next_cycle();
      bus.mem_w_en   = 1'b1;
      bus.address    = 32'd1032;
      bus.write_data = 32'h11223344;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #1;
      check_output("mid_rst_we_n", {31'b0, sram_we_n}, 32'd1);
      check_output("mid_rst_oe", {31'b0, sram_dq_oe}, 32'd0);
      check_output("mid_rst_read_data", bus.read_data, 32'd0);
      check_output("mid_rst_ready", {31'b0, bus.ready}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 1; c <= WR_DONE; c++) begin
         next_cycle();
         @(negedge clk);
         check_output($sformatf("rerun_ready_c%0d", c), {31'b0, bus.ready}, {31'b0, (c == WR_DONE)});
         if (c == 1) check_output("rerun_we_c1", {31'b0, sram_we_n}, 32'd0);
         if (c == 2) check_output("rerun_addr_c2", {14'b0, sram_addr}, 32'd5);
      end
      check_output("rerun_mem_hi", {16'b0, sram_mem[5]}, 32'h00001122);
      check_output("rerun_read_data", bus.read_data, 32'd0);
      go_idle();

      $display("[TB] address wrap");
      apply_stimulus("wrap", 1'b1, 1'b0, 32'd1024 + 32'd524288, 32'd0, RD_DONE);
      check_output("wrap_addr_c1", {14'b0, addr_c1}, 32'd0);
      check_output("wrap_addr_c2", {14'b0, addr_c2}, 32'd1);
      check_output("wrap_read_data", bus.read_data, 32'hA5A5A5A5);
      go_idle();
      apply_stimulus("below", 1'b1, 1'b0, 32'd1020, 32'd0, RD_DONE);
      check_output("below_addr_c1", {14'b0, addr_c1}, 32'h0003FFFE);
      check_output("below_addr_c2", {14'b0, addr_c2}, 32'h0003FFFF);
      go_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
